// File: rtl/tcp_tx_flow_ctrl_pkg.sv
// Shared TCP definitions: controller state encoding, header flag layout and
// wrap-safe 32-bit sequence-number comparisons.
// Pure package, no latency; no handshake of its own.
package tcp_tx_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_SEND   = 2'd2,
        ST_REWIND = 2'd3
    } fc_state_t;

    // TCP header flag bits in on-wire order, shared with the connection controller
    typedef struct packed {
        logic urg;
        logic ack;
        logic psh;
        logic rst;
        logic syn;
        logic fin;
    } tcp_flags_t;

    // a < b in sequence space: the sign of the modulo-2^32 difference decides
    function automatic logic seq_lt(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        return d[31];
    endfunction

    function automatic logic seq_le(input logic [31:0] a, input logic [31:0] b);
        return (a == b) || seq_lt(a, b);
    endfunction

endpackage

// File: rtl/tcp_tx_flow_ctrl_if.sv
// Bundle between the connection controller / TX engine (master) and the send-side
// flow controller (slave). Ports: connection state + ISN, received ACK/window,
// TX engine status in; segment start, sequence/length, in-flight count, retx/abort out.
interface tcp_tx_flow_ctrl_if #(
    parameter int MAX_INFLIGHT = 16
);
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;

    logic          est_i;
    logic [31:0]   isn_i;
    logic          ack_valid_i;
    logic [31:0]   ack_num_i;
    logic [15:0]   window_i;
    logic          trnsmt_busy_i;
    logic          seg_done_i;
    logic          wdat_start_o;
    logic [31:0]   seq_num_o;
    logic [15:0]   data_len_o;
    logic [IW-1:0] inflight_o;
    logic          retx_o;
    logic          abort_o;

    modport master (
        output est_i, isn_i, ack_valid_i, ack_num_i, window_i, trnsmt_busy_i, seg_done_i,
        input  wdat_start_o, seq_num_o, data_len_o, inflight_o, retx_o, abort_o
    );

    modport slave (
        input  est_i, isn_i, ack_valid_i, ack_num_i, window_i, trnsmt_busy_i, seg_done_i,
        output wdat_start_o, seq_num_o, data_len_o, inflight_o, retx_o, abort_o
    );

endinterface

// File: rtl/tcp_rto_timer.sv
// Retransmission timer: load restarts from zero, stop clears, i_en gates counting.
// o_expire is combinational in the cycle the count reaches RTO_CYCLES-1; the timer then idles.
// Ports: clk/rst, i_load, i_stop (wins over load), i_en, o_run (armed), o_expire.
module tcp_rto_timer #(
    parameter int RTO_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_stop,
    input  logic i_en,
    output logic o_run,
    output logic o_expire
);
    localparam int CW = (RTO_CYCLES > 1) ? $clog2(RTO_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          w_hit;

    assign w_hit    = r_run && i_en && (r_cnt == CW'(RTO_CYCLES - 1));
    assign o_expire = w_hit;
    assign o_run    = r_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_stop) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (w_hit) begin
            // disarm so a timeout pending behind a busy segment cannot fire twice
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (r_run && i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tcp_tx_flow_ctrl.sv
// Send-side TCP flow control: SND_UNA/SND_NXT tracking, window + in-flight gating, RTO go-back-N.
// Latency: wdat_start_o one cycle after start conditions hold; ACK effects visible next cycle.
// Backpressure: no start while TX busy, ACK arriving, window exhausted or MAX_INFLIGHT segments out.
// Ports: clk, rst (async high) and the slave side of tcp_tx_flow_ctrl_if.
module tcp_tx_flow_ctrl
    import tcp_tx_flow_ctrl_pkg::*;
#(
    parameter int MSS          = 1450,
    parameter int MAX_INFLIGHT = 16,
    parameter int RTO_CYCLES   = 12500000,
    parameter int MAX_RETX     = 8,
    parameter int MIN_WND      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    tcp_tx_flow_ctrl_if.slave       fc
);
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;
    localparam int RW = $clog2(MAX_RETX + 1);
    localparam logic [32:0] MSS33   = 33'(MSS);
    localparam logic [32:0] MSSM1   = 33'(MSS - 1);

    fc_state_t     r_state;
    logic          r_est_q;
    logic [31:0]   r_snd_una, r_snd_nxt, r_high;
    logic [15:0]   r_wnd;
    logic [IW-1:0] r_inflight;
    logic [RW-1:0] r_retx_cnt;
    logic          r_retx, r_abort, r_start, r_to_pend;
    logic [31:0]   r_seq;
    logic [15:0]   r_len;

    logic [31:0]   w_ack_num, w_nxt_post, w_una_new, w_usable_raw, w_usable;
    logic [32:0]   w_out_bytes;
    logic [IW-1:0] w_inf_calc;
    logic [15:0]   w_len;
    logic [RW-1:0] w_retx_next;
    logic          w_seg_done, w_ack_in, w_ack_acc, w_wnd_upd, w_can_start;
    logic          w_tmr_load, w_tmr_stop, w_tmr_run, w_tmr_expire, w_to, w_give_up, w_rewind_req;

    assign w_ack_num  = fc.ack_num_i;
    assign w_seg_done = (r_state == ST_SEND) && fc.seg_done_i;
    // the ACK range check sees SND_NXT as it will be after a coincident seg_done
    assign w_nxt_post = w_seg_done ? (r_snd_nxt + {16'd0, r_len}) : r_snd_nxt;

    assign w_ack_in   = fc.ack_valid_i && fc.est_i && (r_state != ST_IDLE);
    assign w_ack_acc  = w_ack_in && seq_lt(r_snd_una, w_ack_num) && seq_le(w_ack_num, w_nxt_post);
    assign w_wnd_upd  = w_ack_in && seq_le(r_snd_una, w_ack_num) && seq_le(w_ack_num, w_nxt_post);
    assign w_una_new  = w_ack_acc ? w_ack_num : r_snd_una;

    // segments still outstanding after an ACK: ceil(bytes / MSS)
    assign w_out_bytes = {1'b0, w_nxt_post - w_ack_num};
    assign w_inf_calc  = IW'((w_out_bytes + MSSM1) / MSS33);

    assign w_usable_raw = r_snd_una + {16'd0, r_wnd} - r_snd_nxt;
    assign w_usable     = w_usable_raw[31] ? 32'd0 : w_usable_raw;
    assign w_len        = (w_usable < 32'(MSS)) ? w_usable[15:0] : 16'(MSS);

    assign w_can_start = (r_state == ST_READY) && !fc.trnsmt_busy_i && !fc.ack_valid_i &&
                         (r_inflight < IW'(MAX_INFLIGHT)) && (w_usable >= 32'(MIN_WND));

    // an accepted ACK in the expiry cycle is progress, so that timeout is dropped
    assign w_to         = w_tmr_expire && !w_ack_acc && fc.est_i &&
                          ((r_state == ST_READY) || (r_state == ST_SEND));
    assign w_retx_next  = r_retx_cnt + RW'(1);
    assign w_give_up    = w_to && (w_retx_next == RW'(MAX_RETX));
    assign w_rewind_req = w_to || (r_to_pend && !w_ack_acc);

    assign w_tmr_stop = !fc.est_i || (r_state == ST_IDLE) || w_give_up ||
                        (w_ack_acc && (w_una_new == w_nxt_post));
    assign w_tmr_load = (r_state == ST_REWIND) || w_ack_acc || (w_seg_done && !w_tmr_run);

    tcp_rto_timer #(.RTO_CYCLES(RTO_CYCLES)) u_rto (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tmr_load),
        .i_stop   (w_tmr_stop),
        .i_en     (r_snd_una != r_snd_nxt),
        .o_run    (w_tmr_run),
        .o_expire (w_tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_est_q    <= 1'b0;
            r_snd_una  <= '0;
            r_snd_nxt  <= '0;
            r_high     <= '0;
            r_wnd      <= '0;
            r_inflight <= '0;
            r_retx_cnt <= '0;
            r_retx     <= 1'b0;
            r_abort    <= 1'b0;
            r_start    <= 1'b0;
            r_to_pend  <= 1'b0;
            r_seq      <= '0;
            r_len      <= '0;
        end else begin
            r_est_q <= fc.est_i;
            r_start <= 1'b0;
            r_abort <= 1'b0;
            if (!fc.est_i) begin
                r_state    <= ST_IDLE;
                r_inflight <= '0;
                r_retx     <= 1'b0;
                r_retx_cnt <= '0;
                r_to_pend  <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (!r_est_q) begin
                    r_snd_una  <= fc.isn_i;
                    r_snd_nxt  <= fc.isn_i;
                    r_wnd      <= '0;
                    r_inflight <= '0;
                    r_retx     <= 1'b0;
                    r_retx_cnt <= '0;
                    r_to_pend  <= 1'b0;
                    r_state    <= ST_READY;
                end
            end else begin
                if (w_wnd_upd) r_wnd <= fc.window_i;
                if (w_ack_acc) begin
                    r_snd_una  <= w_ack_num;
                    r_retx_cnt <= '0;
                    r_to_pend  <= 1'b0;
                    if (r_retx && seq_le(r_high, w_ack_num)) r_retx <= 1'b0;
                end
                if (w_ack_acc)       r_inflight <= w_inf_calc;
                else if (w_seg_done) r_inflight <= r_inflight + IW'(1);
                if (w_seg_done)      r_snd_nxt  <= w_nxt_post;

                if (w_give_up) begin
                    r_abort    <= 1'b1;
                    r_state    <= ST_IDLE;
                    r_inflight <= '0;
                    r_retx     <= 1'b0;
                    r_retx_cnt <= '0;
                    r_to_pend  <= 1'b0;
                end else begin
                    if (w_to) r_retx_cnt <= w_retx_next;
                    case (r_state)
                        ST_READY: begin
                            if (w_to) begin
                                r_state <= ST_REWIND;
                            end else if (w_can_start) begin
                                r_start <= 1'b1;
                                r_seq   <= r_snd_nxt;
                                r_len   <= w_len;
                                r_state <= ST_SEND;
                            end
                        end
                        ST_SEND: begin
                            // a timeout mid-segment is held until the engine releases the segment
                            if (w_seg_done) begin
                                r_state <= w_rewind_req ? ST_REWIND : ST_READY;
                            end else if (w_to) begin
                                r_to_pend <= 1'b1;
                            end
                        end
                        ST_REWIND: begin
                            r_high     <= r_snd_nxt;
                            r_snd_nxt  <= w_una_new;
                            r_inflight <= '0;
                            r_retx     <= 1'b1;
                            r_to_pend  <= 1'b0;
                            r_state    <= ST_READY;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign fc.wdat_start_o = r_start;
    assign fc.seq_num_o    = r_seq;
    assign fc.data_len_o   = r_len;
    assign fc.inflight_o   = r_inflight;
    assign fc.retx_o       = r_retx;
    assign fc.abort_o      = r_abort;

endmodule

// File: tb/tb_tcp_tx_flow_ctrl.sv
// Directed bench for tcp_tx_flow_ctrl with MSS=1450, 16 in flight, 1000-cycle RTO, 8 retries.
// Plays the TX engine (seg_done two cycles after each start) and the ACK path.
// Expected values are hand-computed constants.
module tb_tcp_tx_flow_ctrl;
    localparam int MSS  = 1450;
    localparam int MAXI = 16;
    localparam int RTO  = 1000;
    localparam int MAXR = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    tcp_tx_flow_ctrl_if #(.MAX_INFLIGHT(MAXI)) fc_if ();

    tcp_tx_flow_ctrl #(
        .MSS(MSS), .MAX_INFLIGHT(MAXI), .RTO_CYCLES(RTO), .MAX_RETX(MAXR), .MIN_WND(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fc  (fc_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse(input logic [31:0] num, input logic [15:0] win);
        @(posedge clk);
        #1;
        fc_if.ack_valid_i = 1'b1;
        fc_if.ack_num_i   = num;
        fc_if.window_i    = win;
        @(posedge clk);
        #1;
        fc_if.ack_valid_i = 1'b0;
    endtask

    // waits for a start pulse, captures it, then answers with seg_done
    task automatic send_one(input int budget, output logic [31:0] seq, output logic [15:0] len,
                            output logic ok);
        ok  = 1'b0;
        seq = '0;
        len = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (fc_if.wdat_start_o) begin
                ok  = 1'b1;
                seq = fc_if.seq_num_o;
                len = fc_if.data_len_o;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1 fc_if.seg_done_i = 1'b1;
            @(posedge clk);
            #1 fc_if.seg_done_i = 1'b0;
        end
    endtask

    task automatic count_starts(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (fc_if.wdat_start_o) c++;
        end
    endtask

    task automatic restart(input logic [31:0] isn);
        @(posedge clk);
        #1 fc_if.est_i = 1'b0;
        tick(2);
        fc_if.isn_i = isn;
        fc_if.est_i = 1'b1;
        tick(2);
    endtask

    initial begin : stim
        logic [31:0] seq;
        logic [15:0] len;
        logic        ok;
        int          c, ab, cnt;

        fc_if.est_i = 1'b0; fc_if.isn_i = '0; fc_if.ack_valid_i = 1'b0; fc_if.ack_num_i = '0;
        fc_if.window_i = '0; fc_if.trnsmt_busy_i = 1'b0; fc_if.seg_done_i = 1'b0;

        // reset state
        tick(3);
        check("rst_start",    32'(fc_if.wdat_start_o), 32'd0);
        check("rst_seq",      fc_if.seq_num_o,         32'd0);
        check("rst_len",      32'(fc_if.data_len_o),   32'd0);
        check("rst_inflight", 32'(fc_if.inflight_o),   32'd0);
        check("rst_retx",     32'(fc_if.retx_o),       32'd0);
        check("rst_abort",    32'(fc_if.abort_o),      32'd0);
        rst = 1'b0;
        tick(2);

        // establish, window opens with a duplicate ACK; window 0 before that
        fc_if.isn_i = 32'h0000_1000;
        fc_if.est_i = 1'b1;
        tick(2);
        count_starts(5, c);
        check("no_start_wnd0", 32'(c), 32'd0);
        ack_pulse(32'h0000_1000, 16'hFFFF);

        // 16 back-to-back segments, the 17th is held by the in-flight limit
        for (int k = 0; k < 16; k++) begin
            send_one(50, seq, len, ok);
            check("burst_seq", seq, 32'h0000_1000 + 32'(k * MSS));
            check("burst_len", 32'(len), 32'd1450);
        end
        count_starts(20, c);
        check("hold_17th", 32'(c), 32'd0);
        check("inflight_16", 32'(fc_if.inflight_o), 32'd16);

        // ACK two segments -> 14 outstanding, two more starts, then held again
        ack_pulse(32'h0000_1000 + 32'd2900, 16'hFFFF);
        check("inflight_14", 32'(fc_if.inflight_o), 32'd14);
        send_one(50, seq, len, ok);
        check("after_ack_seq0", seq, 32'h0000_1000 + 32'd23200);
        send_one(50, seq, len, ok);
        check("after_ack_seq1", seq, 32'h0000_1000 + 32'd24650);
        count_starts(10, c);
        check("hold_again", 32'(c), 32'd0);
        check("inflight_16b", 32'(fc_if.inflight_o), 32'd16);

        // full ACK with window closed: nothing outstanding, no starts
        ack_pulse(32'h0000_75F4, 16'd0);
        check("inflight_0", 32'(fc_if.inflight_o), 32'd0);

        // stale ACK and ACK beyond SND_NXT must not touch window or SND_UNA
        ack_pulse(32'h0000_1000, 16'd2000);
        ack_pulse(32'h0000_75F5, 16'd2000);
        count_starts(10, c);
        check("bad_ack_ignored", 32'(c), 32'd0);
        check("bad_ack_inflight", 32'(fc_if.inflight_o), 32'd0);

        // window 2000 -> 1450 + 550, then window exhausted
        ack_pulse(32'h0000_75F4, 16'd2000);
        send_one(50, seq, len, ok);
        check("wnd_seq0", seq, 32'h0000_75F4);
        check("wnd_len0", 32'(len), 32'd1450);
        send_one(50, seq, len, ok);
        check("wnd_seq1", seq, 32'h0000_7B9E);
        check("wnd_len1", 32'(len), 32'd550);
        count_starts(15, c);
        check("wnd_exhausted", 32'(c), 32'd0);
        check("wnd_inflight", 32'(fc_if.inflight_o), 32'd2);
        ack_pulse(32'h0000_7DC4, 16'd0);
        check("wnd_acked", 32'(fc_if.inflight_o), 32'd0);
        check("no_retx", 32'(fc_if.retx_o), 32'd0);

        // sequence wrap across 2^32
        restart(32'hFFFF_FC00);
        ack_pulse(32'hFFFF_FC00, 16'd2000);
        send_one(50, seq, len, ok);
        check("wrap_seq0", seq, 32'hFFFF_FC00);
        send_one(50, seq, len, ok);
        check("wrap_seq1", seq, 32'h0000_01AA);
        check("wrap_len1", 32'(len), 32'd550);
        ack_pulse(32'h0000_01AA, 16'd0);
        check("wrap_ack_acc", 32'(fc_if.inflight_o), 32'd1);
        ack_pulse(32'h0000_03D0, 16'd0);
        check("wrap_ack_all", 32'(fc_if.inflight_o), 32'd0);

        // retransmission timeout, go-back-N, give-up after 8 timeouts
        restart(32'h0000_5000);
        ack_pulse(32'h0000_5000, 16'd1450);
        send_one(50, seq, len, ok);
        check("rto_first_seq", seq, 32'h0000_5000);
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            @(negedge clk);
            cnt++;
            if (fc_if.retx_o) ok = 1'b1;
        end
        check("retx_seen", 32'(ok), 32'd1);
        check("rto_window", 32'(cnt >= 995 && cnt <= 1010), 32'd1);
        check("retx_inflight", 32'(fc_if.inflight_o), 32'd0);
        for (int r = 1; r < MAXR; r++) begin
            send_one(1200, seq, len, ok);
            check("resend_seen", 32'(ok), 32'd1);
            check("resend_seq", seq, 32'h0000_5000);
        end
        check("retx_held", 32'(fc_if.retx_o), 32'd1);
        ab = 0;
        c  = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (fc_if.abort_o) ab++;
            if (fc_if.wdat_start_o) c++;
        end
        check("abort_once", 32'(ab), 32'd1);
        check("abort_no_start", 32'(c), 32'd0);
        check("abort_retx_clr", 32'(fc_if.retx_o), 32'd0);
        check("abort_inflight", 32'(fc_if.inflight_o), 32'd0);

        // asynchronous reset while a segment is in SEND
        restart(32'h0000_9000);
        ack_pulse(32'h0000_9000, 16'd1450);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (fc_if.wdat_start_o) ok = 1'b1;
        end
        check("send_seen", 32'(ok), 32'd1);
        check("send_seq", fc_if.seq_num_o, 32'h0000_9000);
        rst = 1'b1;
        #1;
        check("arst_start", 32'(fc_if.wdat_start_o), 32'd0);
        check("arst_seq",   fc_if.seq_num_o,         32'd0);
        check("arst_len",   32'(fc_if.data_len_o),   32'd0);
        check("arst_infl",  32'(fc_if.inflight_o),   32'd0);
        tick(3);
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tcp_tx_flow_ctrl.md
Name: tcp_tx_flow_ctrl

Overview:
Parametrised send-side flow controller for an ESTABLISHED TCP connection. Successor to the fixed-size, fixed-count data-start logic in the TCP connection controller. Tracks SND_UNA/SND_NXT, honours the peer's advertised window and an in-flight segment limit, and paces data-segment starts to the TX engine. Adds ACK validation, wrap-safe sequence arithmetic, a retransmission timer with go-back-N rewind, and a give-up abort.

Parameters:
MSS, 1450, payload bytes per full data segment (1..65535)
MAX_INFLIGHT, 16, max unacknowledged segments (power of 2, 2..64)
RTO_CYCLES, 12500000, retransmission timeout in clk cycles (100 ms at 125 MHz)
MAX_RETX, 8, consecutive timeouts without ACK progress before abort
MIN_WND, 1, minimum usable window in bytes required to start a segment

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
est_i  in  1  connection in ESTABLISHED; rising edge loads isn_i
isn_i  in  32  first data sequence number (ISS+1)
ack_valid_i  in  1  one-cycle pulse: received segment with ACK flag consumed
ack_num_i  in  32  received acknowledgment number
window_i  in  16  received advertised window
trnsmt_busy_i  in  1  TX engine busy
seg_done_i  in  1  one-cycle pulse: TX engine finished current data segment
wdat_start_o  out  1  one-cycle pulse: start data segment
seq_num_o  out  32  sequence number of segment being started
data_len_o  out  16  payload length of segment being started
inflight_o  out  $clog2(MAX_INFLIGHT)+1  unacknowledged segment count
retx_o  out  1  high while resending after a timeout
abort_o  out  1  one-cycle pulse: MAX_RETX reached; controller returns to IDLE

Behaviour:
- Reset: every output 0; internal SND_UNA, SND_NXT, wnd, timer, retx count 0; state IDLE.
- Sequence compare: a<b means signed(a-b)<0 on 32 bits; all add/sub wrap modulo 2^32.
- States: IDLE, READY, SEND, REWIND.
- IDLE: on est_i rising edge, SND_UNA=SND_NXT=isn_i, wnd=0 -> READY. est_i low in any state -> IDLE next cycle, pending start dropped, no abort.
- READY: usable = SND_UNA + wnd - SND_NXT (32-bit, clamped to 0 if negative). Start when !trnsmt_busy_i & !ack_valid_i & inflight<MAX_INFLIGHT & usable>=MIN_WND. Then wdat_start_o=1 for one cycle; seq_num_o=SND_NXT; data_len_o=min(MSS,usable); -> SEND. Latency: start pulse one cycle after conditions hold.
- SEND: wait seg_done_i. Then SND_NXT+=data_len_o, inflight+=1, timer armed if it was idle -> READY. No new start until seg_done_i.
- ACK handling in every non-IDLE state: accept only if SND_UNA < ack_num_i <= SND_NXT (acceptable). On accept: SND_UNA=ack_num_i; inflight recomputed as ceil((SND_NXT-SND_UNA)/MSS); timer restarted, or stopped if SND_UNA==SND_NXT; retx count cleared; retx_o cleared when SND_UNA reaches the pre-timeout SND_NXT. Window update: wnd=window_i if ack_num_i >= SND_UNA, including duplicate ACKs. Otherwise ignore the ACK.
- Timer: counts while SND_UNA!=SND_NXT. When it reaches RTO_CYCLES-1: retx count+=1. If the new count equals MAX_RETX: abort_o pulse -> IDLE. Else -> REWIND.
- REWIND: entered from READY, or from SEND after seg_done_i. Records high mark=SND_NXT; SND_NXT=SND_UNA; inflight=0; retx_o=1; timer restarted -> READY. Go-back-N resend follows from normal READY operation.
- Simultaneous events: an ACK in the same cycle as seg_done_i applies both; ACK update uses the post-seg_done SND_NXT for the range check. An ACK in the same cycle as timer expiry takes priority, and the timeout is discarded.
- Window 0: no starts; the timer keeps running only if data is outstanding. Zero-window probe is not supported.

Decomposition:
- Shared tcp package: seq_lt/seq_le compare functions, state encoding, flag constants shared with the TCP connection controller.
- One sub-module: tcp_rto_timer (load/stop/expire counter, parametrised by RTO_CYCLES).

Test Plan:
- isn_i=0x1000, ACK wnd=65535, MSS=1450, no ACKs after -> 16 starts at seq 0x1000+k*1450, k=0..15; 17th held; inflight_o=16.
- Then ack_num_i=0x1000+2900 -> inflight_o=14; two further starts follow.
- window_i=2000 with nothing outstanding -> first segment len 1450, second len 550, then no start until the next ACK.
- isn_i=0xFFFFFC00 -> seq wraps to 0x000001AA on the next segment; ACK 0x000001AA is accepted.
- No ACK, RTO_CYCLES=1000 -> at cycle 1000 retx_o=1 and seq_num_o restarts at SND_UNA. After the 8th consecutive timeout, abort_o pulses once and the block is IDLE.
- Stale ACK below SND_UNA and ACK above SND_NXT -> ignored, no state change. Reset asserted in SEND -> all outputs 0 immediately.
